// File: rtl/mult_seq_if.sv
// Operand/result bundle for the sequential Booth multiplier.
interface mult_seq_if;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/mult_seq.sv
// Sequential signed 32x32 multiplier: radix-2 Booth, one step per cycle,
// 33-bit accumulator built from 8-bit carry-lookahead slices.

// 8-bit carry-lookahead slice: every carry is expanded from g/p and cin.
module mult_seq_cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  logic [7:0] p, g;
  logic [8:0] c;
  logic       pp;

  // flat lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    pp   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin);
    end
    s    = p ^ c[7:0];
    cout = c[8];
  end
endmodule

module mult_seq (
  input  logic      clock,
  input  logic      reset,
  mult_seq_if.slave bus
);
  localparam int NUM_SLICES = 4;
  localparam int SLICE_W    = 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, nstate;
  logic [32:0] ac, m;
  logic [31:0] q;
  logic        q_1;
  logic [4:0]  cnt;
  logic [31:0] res_q;
  logic        exc_q, rdy_q;

  logic [1:0]  booth;
  logic        sub;
  logic [32:0] addend, sum, ac_new;
  logic [NUM_SLICES:0] carry;
  logic [32:0] prod_top;

  assign booth  = {q[0], q_1};
  assign sub    = (booth == 2'b10);
  assign addend = sub ? ~m : m;
  assign carry[0] = sub;

  genvar k;
  generate
    for (k = 0; k < NUM_SLICES; k++) begin : g_slice
      mult_seq_cla8 u_cla (
        .a   (ac[k*SLICE_W +: SLICE_W]),
        .b   (addend[k*SLICE_W +: SLICE_W]),
        .cin (carry[k]),
        .s   (sum[k*SLICE_W +: SLICE_W]),
        .cout(carry[k+1])
      );
    end
  endgenerate

  // sign bit extension on top of the 32-bit slice chain; carry-out dropped
  assign sum[32] = ac[32] ^ addend[32] ^ carry[NUM_SLICES];

  assign ac_new   = (booth == 2'b01 || booth == 2'b10) ? sum : ac;
  // product bits [63:31]; all equal means the result fits in signed 32
  assign prod_top = {ac[31:0], q[31]};

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  // next-state: start only from IDLE, 32 steps in BUSY, one cycle in DONE
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (bus.ctrl_MULT) nstate = BUSY;
      BUSY:    if (cnt == 5'd31)  nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // datapath: operand load, Booth step + arithmetic shift, result capture
  always_ff @(posedge clock) begin
    if (reset) begin
      ac    <= '0;
      m     <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
      res_q <= '0;
      exc_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state)
        IDLE: if (bus.ctrl_MULT) begin
          m   <= {bus.data_operandA[31], bus.data_operandA};
          ac  <= '0;
          q   <= bus.data_operandB;
          q_1 <= 1'b0;
          cnt <= '0;
        end
        BUSY: begin
          {ac, q, q_1} <= {ac_new[32], ac_new, q};
          if (cnt != 5'd31) cnt <= cnt + 5'd1;
        end
        DONE: begin
          res_q <= q;
          exc_q <= !((&prod_top) || !(|prod_top));
          rdy_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.data_result    = res_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
endmodule

// File: tb/tb_mult_seq.sv
// Directed + random bench for mult_seq against a 64-bit arithmetic model.
module tb_mult_seq;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   chk   = 0;
  int   errs  = 0;

  mult_seq_if bus ();

  mult_seq dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts a*b at the next edge (edge 0). rst_at/pul_at name the edge index
  // at which reset or a stray ctrl_MULT (operands pa,pb) is applied; -1 = none.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int rst_at, input int pul_at,
                        input logic [31:0] pa, input logic [31:0] pb,
                        output logic [31:0] er);
    longint      p;
    logic        ee;
    int          first, npul;
    logic [31:0] res;
    logic        exc;
    p  = longint'($signed(a)) * longint'($signed(b));
    er = p[31:0];
    ee = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    first = -1; npul = 0; res = 'x; exc = 1'bx;

    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = 1'b1;
    @(posedge clock); #1;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;

    for (int i = 1; i <= 40; i++) begin
      reset         = (i == rst_at);
      bus.ctrl_MULT = (i == pul_at);
      if (i == pul_at) begin
        bus.data_operandA = pa;
        bus.data_operandB = pb;
      end
      @(posedge clock); #1;
      if (bus.data_resultRDY === 1'b1) begin
        npul++;
        if (first < 0) begin
          first = i;
          res   = bus.data_result;
          exc   = bus.data_exception;
        end
      end
      if (npul > 0 && rst_at < 0) break;
    end
    reset = 1'b0;
    bus.ctrl_MULT = 1'b0;

    if (rst_at < 0) begin
      check({tag, " pulses"}, 32'(npul), 32'd1);
      check({tag, " latency"}, 32'(first), 32'd33);
      check({tag, " result"}, res, er);
      check({tag, " exception"}, {31'd0, exc}, {31'd0, ee});
    end else begin
      check({tag, " pulses"}, 32'(npul), 32'd0);
      check({tag, " result"}, bus.data_result, 32'd0);
      check({tag, " exception"}, {31'd0, bus.data_exception}, 32'd0);
    end
  endtask

  logic [31:0] er, ra, rb;
  int          stray;

  initial begin
    bus.data_operandA = 32'h1234_5678;
    bus.data_operandB = 32'h9abc_def0;
    bus.ctrl_MULT     = 1'b1;   // reset must win over a start request
    reset             = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset result", bus.data_result, 32'd0);
    check("reset exception", {31'd0, bus.data_exception}, 32'd0);
    check("reset rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    reset = 1'b0;
    bus.ctrl_MULT = 1'b0;

    // first start on the first edge after reset release
    run_op("3x5", 32'd3, 32'd5, -1, -1, 0, 0, er);
    run_op("m7x6", -32'sd7, 32'd6, -1, -1, 0, 0, er);
    run_op("ovf16", 32'h0001_0000, 32'h0001_0000, -1, -1, 0, 0, er);
    run_op("min_x_m1", 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 0, 0, er);
    run_op("min_x_1", 32'h8000_0000, 32'd1, -1, -1, 0, 0, er);
    run_op("min_x_min", 32'h8000_0000, 32'h8000_0000, -1, -1, 0, 0, er);
    run_op("max_x_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1, -1, 0, 0, er);

    // reset mid-BUSY aborts, then a fresh op runs normally
    run_op("abort12x12", 32'd12, 32'd12, 11, -1, 0, 0, er);
    run_op("2xm3", 32'd2, -32'sd3, -1, -1, 0, 0, er);

    // stray start during BUSY is ignored
    run_op("4x4_stray", 32'd4, 32'd4, -1, 6, 32'd9, 32'd9, er);

    // result holds while idle, no extra pulse
    stray = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (bus.data_resultRDY === 1'b1) stray++;
    end
    check("hold result", bus.data_result, 32'd16);
    check("hold no pulse", 32'(stray), 32'd0);

    // random back-to-back ops, some operands forced to edge values
    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: ra = ra >>> 16;
        3: rb = 32'($signed(rb[15:0]));
        default: ;
      endcase
      run_op($sformatf("rnd%0d", n), ra, rb, -1, -1, 0, 0, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", chk, errs);
    $finish;
  end
endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 The block SHALL have port clock, input, 1 bit: rising-edge clock for all state.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clock.
REQ-003 The block SHALL have port data_operandA, input, 32 bits: signed two's-complement multiplicand.
REQ-004 The block SHALL have port data_operandB, input, 32 bits: signed two's-complement multiplier.
REQ-005 The block SHALL have port ctrl_MULT, input, 1 bit: start request, sampled each cycle.
REQ-006 The block SHALL have port data_result, output, 32 bits: low 32 bits of the signed product.
REQ-007 The block SHALL have port data_exception, output, 1 bit: the product does not fit in signed 32 bits.
REQ-008 The block SHALL have port data_resultRDY, output, 1 bit: one-cycle pulse marking a valid result.
REQ-009 The block SHALL have no parameters; all widths are fixed at 32 bits.

Function
REQ-010 The block SHALL implement three states: IDLE, BUSY and DONE.
REQ-011 In IDLE, when ctrl_MULT=1 at a rising edge, the block SHALL latch both operands and enter BUSY.
- Multiplicand register M is 33 bits, sign-extended from data_operandA.
- Accumulator AC (33 bits) is set to 0.
- Q is set to data_operandB.
- Booth bit q_1 is set to 0.
- Iteration counter is set to 0.
REQ-012 In BUSY, each cycle SHALL perform one radix-2 Booth step on {Q[0], q_1}:
- 01: AC = AC + M.
- 10: AC = AC - M.
- 00 or 11: AC unchanged.
- Then {AC, Q, q_1} is arithmetic-shifted right by 1, replicating AC[32].
REQ-013 Additions and subtractions SHALL use a 33-bit adder built from the team's 8-bit carry-lookahead slices plus a top-bit extension.
- Subtraction is ~M with carry-in 1.
- Carry-out is discarded.
REQ-014 After exactly 32 Booth steps the block SHALL enter DONE.
- The counter runs 0..31 with no wrap.
- Transition happens on the edge where counter=31.
REQ-015 In DONE the block SHALL, for exactly one cycle:
- drive data_resultRDY=1;
- update data_result to Q, the low product half;
- then return to IDLE.
REQ-016 data_exception SHALL be 1 exactly when the 64-bit product bits [63:31] are not all equal (AC[31:0] concatenated with Q[31]).
- It updates in the same cycle as data_result.
REQ-017 data_result and data_exception SHALL hold their values until the next DONE or reset.
REQ-018 Latency: with ctrl_MULT sampled at edge 0, data_resultRDY SHALL be high during the cycle after edge 33.
- data_result is valid in that same cycle.
REQ-019 ctrl_MULT asserted in BUSY or DONE SHALL be ignored, with no restart and no queuing.
REQ-020 ctrl_MULT asserted in the IDLE cycle right after DONE SHALL start a new operation normally.
- This gives back-to-back throughput of one result per 34 cycles.
REQ-021 Operand changes after the start edge SHALL NOT affect the result in progress.
REQ-022 The operand pair (-2^31, x) SHALL be handled without internal overflow, because of the 33-bit AC and M.

Reset
REQ-023 reset=1 at a rising edge SHALL force:
- state to IDLE;
- AC, Q, M, q_1 and the counter to 0;
- data_result=0, data_exception=0 and data_resultRDY=0.
REQ-024 Reset in any state, including mid-BUSY, SHALL abort the operation with no data_resultRDY pulse.
REQ-025 reset SHALL take priority over ctrl_MULT in the same cycle.
REQ-026 The first start SHALL be accepted on the first edge after reset deasserts.

Verification
REQ-027 Start with 3 x 5 -> data_resultRDY pulses 33 cycles after the start edge, data_result=15, data_exception=0.
REQ-028 Start with -7 x 6 -> data_result=0xFFFFFFD6, data_exception=0.
REQ-029 Start with 0x00010000 x 0x00010000 -> data_result=0, data_exception=1.
REQ-030 Operand-boundary cases:
- 0x80000000 x 0xFFFFFFFF -> data_result=0x80000000, data_exception=1.
- 0x80000000 x 1 -> data_result=0x80000000, data_exception=0.
REQ-031 Start 12 x 12, assert reset at BUSY cycle 10, then start 2 x -3 -> no data_resultRDY pulse for the first operation; the second gives data_result=0xFFFFFFFA.
REQ-032 Start 4 x 4, pulse ctrl_MULT with 9 x 9 at BUSY cycle 5 -> a single data_resultRDY pulse at the original time with data_result=16.
